// File: rtl/genetic_circuit_pkg.sv
// Shared definitions for the genetic logic circuit reporter path.
//   REPORTER_W       : number of reporter outputs ({out2, out1})
//   reporter_level_t : debounced reporter code
//   reporter_event_t : event record {timestamp, level} at the default
//                      timestamp width; modules with a different TS_WIDTH
//                      declare the same layout locally.
//   ST_IDLE/ST_QUAL  : debouncer FSM encodings
package genetic_circuit_pkg;

  localparam int REPORTER_W       = 2;
  localparam int TS_WIDTH_DEFAULT = 16;

  typedef logic [REPORTER_W-1:0] reporter_level_t;

  typedef struct packed {
    logic [TS_WIDTH_DEFAULT-1:0] timestamp;
    reporter_level_t             level;
  } reporter_event_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_QUAL = 1'b1;

endpackage

// File: rtl/event_fifo.sv
// Generic first-word-fall-through FIFO.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data (ignored when full without a pop)
//   pop        : read request (ignored when empty)
//   dout       : head entry, valid whenever !empty; zero when empty
//   full/empty : occupancy flags
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_d = do_push ? wr_q + 1'b1 : wr_q;
  assign rd_d = do_pop  ? rd_q + 1'b1 : rd_q;

  assign dout = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/reporter_event_capture.sv
// Captures qualified level changes of the genetic circuit's two reporters.
//   clk, rst_n     : clock, asynchronous active-low reset
//   out1, out2     : asynchronous reporter outputs
//   enable         : capture enable (freezes level/timestamp when low)
//   evt_valid      : an event is at the FIFO head
//   evt_ready      : consumer takes the head event
//   evt_data       : head event {timestamp, out2_level, out1_level}
//   level          : current debounced {out2, out1}
//   overflow       : sticky flag, an event was dropped on a full FIFO
//   clear_overflow : clears overflow (a same-cycle drop wins)
module reporter_event_capture
  import genetic_circuit_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int TS_WIDTH      = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                out1,
  input  logic                out2,
  input  logic                enable,
  input  logic                evt_ready,
  output logic                evt_valid,
  output logic [TS_WIDTH+1:0] evt_data,
  output logic [1:0]          level,
  output logic                overflow,
  input  logic                clear_overflow
);

  typedef struct packed {
    logic [TS_WIDTH-1:0] timestamp;
    reporter_level_t     level;
  } evt_rec_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  reporter_level_t     sync1_q, samp_q;
  reporter_level_t     level_q, level_d;
  reporter_level_t     cand_q, cand_d;
  logic [0:0]          state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [TS_WIDTH-1:0] ts_q;
  logic                overflow_q;
  logic                commit, fifo_full, fifo_empty, pop, push, drop;
  evt_rec_t            ev_in;

  // Stage 1: two-flop synchronizer; samp_q is the only view the debouncer has.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      samp_q  <= '0;
    end else begin
      sync1_q <= {out2, out1};
      samp_q  <= sync1_q;
    end
  end

  // Stage 2: debouncer. A new code must be seen STABLE_CYCLES times in a row;
  // any different code restarts the count, a return to level abandons it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    level_d = level_q;
    commit  = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (samp_q != level_q) begin
            if (STABLE_CYCLES == 1) begin
              commit  = 1'b1;
              level_d = samp_q;
            end else begin
              state_d = ST_QUAL;
              cand_d  = samp_q;
              cnt_d   = 8'd1;
            end
          end
        end
        default: begin
          if (samp_q == level_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (samp_q != cand_q) begin
            cand_d = samp_q;
            cnt_d  = 8'd1;
          end else if (cnt_q == CNT_LAST) begin
            commit  = 1'b1;
            level_d = cand_q;
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      level_q <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      level_q <= level_d;
      if (enable) ts_q <= ts_q + TS_WIDTH'(1);
    end
  end

  // Stage 3: event buffering. The record carries the pre-increment timestamp
  // of the commit cycle; a full FIFO only accepts when it pops the same cycle.
  assign ev_in.timestamp = ts_q;
  assign ev_in.level     = level_d;

  assign pop  = !fifo_empty && evt_ready;
  assign push = commit && (!fifo_full || pop);
  assign drop = commit && fifo_full && !pop;

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (TS_WIDTH + 2)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ev_in),
    .dout  (evt_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              overflow_q <= 1'b0;
    else if (drop)           overflow_q <= 1'b1;
    else if (clear_overflow) overflow_q <= 1'b0;
  end

  assign evt_valid = !fifo_empty;
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_reporter_event_capture.sv
// Directed bench for reporter_event_capture (STABLE_CYCLES=4, TS_WIDTH=16,
// FIFO_DEPTH=4). Inputs change on the falling edge, outputs are compared on
// the following falling edge.
module tb_reporter_event_capture;

  localparam int TSW = 16;
  localparam int EW  = TSW + 2;

  typedef struct {
    logic          o1;
    logic          o2;
    logic          chk;
    logic [1:0]    lvl;
    logic          vld;
    logic [EW-1:0] data;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, out1, out2, enable, evt_ready, clear_overflow;
  logic          evt_valid, overflow;
  logic [EW-1:0] evt_data;
  logic [1:0]    level;

  int            n_vec = 0;
  int            n_bad = 0;
  logic [TSW-1:0] ts_ref = '0;
  logic [EW-1:0] ev [0:7];
  vec_t          tbl [1:50];

  always #5 clk = ~clk;

  // Reference timestamp: counts enabled edges since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ts_ref <= '0;
    else if (enable) ts_ref <= ts_ref + TSW'(1);
  end

  reporter_event_capture #(
    .STABLE_CYCLES (4),
    .TS_WIDTH      (TSW),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .out1           (out1),
    .out2           (out2),
    .enable         (enable),
    .evt_ready      (evt_ready),
    .evt_valid      (evt_valid),
    .evt_data       (evt_data),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Toggle out1 and follow it to its commit edge (6 edges later).
  task automatic change(input logic clr_at, input logic rdy_at,
                        input logic [1:0] exp_lvl, output logic [EW-1:0] evr);
    logic [TSW-1:0] t;
    t = ts_ref + TSW'(5);
    out1 = ~out1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_commit_level", 32'(level), 32'(exp_lvl ^ 2'b01));
    clear_overflow = clr_at;
    evt_ready      = rdy_at;
    tick();
    clear_overflow = 1'b0;
    evt_ready      = 1'b0;
    check("commit_level", 32'(level), 32'(exp_lvl));
    evr = {t, exp_lvl};
  endtask

  task automatic drain(input int first, input int n);
    evt_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      check("drain_valid", 32'(evt_valid), 32'(1));
      check("drain_data", 32'(evt_data), 32'(ev[first+k]));
      tick();
    end
    evt_ready = 1'b0;
    check("drain_empty", 32'(evt_valid), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]     lv;
    logic [TSW-1:0] t;

    // Tests 1-3 timeline: out1 rises before edge 10, out2 pulses for edges
    // 20-21, out1 falls before edge 31, rises before 40, out2 rises before 42.
    for (int e = 1; e <= 50; e++) begin
      tbl[e].o1   = ((e >= 10) && (e < 31)) || (e >= 40);
      tbl[e].o2   = (e == 20) || (e == 21) || (e >= 42);
      tbl[e].chk  = 1'b0;
      tbl[e].lvl  = 2'b00;
      tbl[e].vld  = 1'b0;
      tbl[e].data = '0;
    end
    tbl[14] = '{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, EW'(0)};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, EW'(57)};   // {ts 14, 01}
    tbl[16] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, EW'(0)};
    tbl[23] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, EW'(0)};
    tbl[24] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, EW'(0)};
    tbl[30] = '{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, EW'(0)};
    tbl[35] = '{1'b0, 1'b0, 1'b1, 2'b01, 1'b0, EW'(0)};
    tbl[36] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b1, EW'(140)};  // {ts 35, 00}
    tbl[37] = '{1'b0, 1'b0, 1'b1, 2'b00, 1'b0, EW'(0)};
    tbl[46] = '{1'b1, 1'b1, 1'b1, 2'b00, 1'b0, EW'(0)};
    tbl[47] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b1, EW'(187)};  // {ts 46, 11}
    tbl[48] = '{1'b1, 1'b1, 1'b1, 2'b11, 1'b0, EW'(0)};

    // Reset state
    rst_n = 1'b0; out1 = 1'b0; out2 = 1'b0; enable = 1'b1;
    evt_ready = 1'b1; clear_overflow = 1'b0;
    #2;
    check("rst_valid", 32'(evt_valid), 32'(0));
    check("rst_data", 32'(evt_data), 32'(0));
    check("rst_level", 32'(level), 32'(0));
    check("rst_overflow", 32'(overflow), 32'(0));
    #1 rst_n = 1'b1;

    for (int e = 1; e <= 50; e++) begin
      out1 = tbl[e].o1;
      out2 = tbl[e].o2;
      tick();
      if (tbl[e].chk) begin
        check($sformatf("tbl%0d_level", e), 32'(level), 32'(tbl[e].lvl));
        check($sformatf("tbl%0d_valid", e), 32'(evt_valid), 32'(tbl[e].vld));
        if (tbl[e].vld)
          check($sformatf("tbl%0d_data", e), 32'(evt_data), 32'(tbl[e].data));
      end
    end

    // Test 4: five changes with no consumer; the fifth is dropped while
    // clear_overflow is also asserted, so overflow must still set.
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lv = (i % 2 == 0) ? 2'b10 : 2'b11;
      change(i == 4, 1'b0, lv, ev[i]);
      check("t4_valid", 32'(evt_valid), 32'(1));
      check("t4_head", 32'(evt_data), 32'(ev[0]));
      check("t4_overflow", 32'(overflow), 32'(i == 4));
    end
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("t4_overflow_cleared", 32'(overflow), 32'(0));
    drain(0, 4);

    // Test 5: full FIFO, consumer pops on the commit cycle.
    for (int i = 0; i < 5; i++) begin
      lv = (i % 2 == 0) ? 2'b11 : 2'b10;
      change(1'b0, i == 4, lv, ev[i]);
    end
    check("t5_overflow", 32'(overflow), 32'(0));
    check("t5_valid", 32'(evt_valid), 32'(1));
    check("t5_head", 32'(evt_data), 32'(ev[1]));
    drain(1, 4);

    // Enable low: change is ignored and timestamp frozen, then re-qualified.
    enable = 1'b0;
    out1 = 1'b0;
    repeat (10) tick();
    check("en_level_frozen", 32'(level), 32'(2'b11));
    check("en_no_event", 32'(evt_valid), 32'(0));
    t = ts_ref + TSW'(3);
    enable = 1'b1;
    repeat (3) tick();
    check("en_requal_level", 32'(level), 32'(2'b11));
    tick();
    check("en_commit_level", 32'(level), 32'(2'b10));
    check("en_commit_valid", 32'(evt_valid), 32'(1));
    check("en_commit_data", 32'(evt_data), 32'({t, 2'b10}));
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    check("en_popped", 32'(evt_valid), 32'(0));

    // Test 6: reset mid-qualification with two events queued.
    change(1'b0, 1'b0, 2'b11, ev[0]);
    change(1'b0, 1'b0, 2'b10, ev[1]);
    check("t6_queued_head", 32'(evt_data), 32'(ev[0]));
    out1 = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(evt_valid), 32'(0));
    check("t6_rst_level", 32'(level), 32'(0));
    check("t6_rst_overflow", 32'(overflow), 32'(0));
    out1 = 1'b0;
    out2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    check("t6_no_stale_valid", 32'(evt_valid), 32'(0));
    check("t6_level_after", 32'(level), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
